// File: rtl/sdram_to_uart.sv
// Response path from the SDRAM controller to the UART transmitter: frames read words
// as 'D' hi lo ... 'E', acknowledges writes with 'K', and reports stalls with 'T'.
module sdram_to_uart #(
  parameter int          width   = 8,
  parameter int          FIFO_AW = 2,
  parameter logic [15:0] TIMEOUT = 16'hEEEE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start_stb,
  input  logic [15:0]      start_len,
  input  logic             start_rd,
  output logic             start_ack,
  input  logic [15:0]      rd_data,
  input  logic             rd_stb,
  output logic             rd_ack,
  input  logic             wt_done,
  output logic [width-1:0] o_data,
  output logic             o_stb,
  input  logic             o_ack,
  output logic             busy
);

  // state | meaning: IDLE wait start | HDR send 'D' | WAIT await word | HI/LO send word bytes
  // TRL send 'E' | WCNT count write completions | WACK send 'K' | TOUT send 'T'
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WAIT, S_HI, S_LO, S_TRL, S_WCNT, S_WACK, S_TOUT
  } state_t;

  state_t               state_q;
  logic [15:0]          len_q, cnt_q, timer_q;
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic                 full_q, empty_q;
  logic [15:0]          mem_q [2**FIFO_AW];

  logic                 rx_state, push, pop, timer_tc;
  logic [15:0]          head, cnt_inc, timer_inc;
  logic [7:0]           byte_d;

  assign rx_state  = state_q inside {S_WAIT, S_HI, S_LO};
  assign rd_ack    = !RST && rd_stb && !full_q && rx_state;
  assign start_ack = !RST && start_stb && (state_q == S_IDLE);
  assign push      = rd_ack;
  assign pop       = (state_q == S_LO) && o_ack;
  assign head      = mem_q[rd_ptr_q];
  assign cnt_inc   = cnt_q + 16'd1;
  assign timer_inc = timer_q + 16'd1;
  assign timer_tc  = (timer_inc == TIMEOUT);

  always_comb begin
    byte_d = 8'h00;
    case (state_q)
      S_HDR:   byte_d = 8'h44;
      S_HI:    byte_d = head[15:8];
      S_LO:    byte_d = head[7:0];
      S_TRL:   byte_d = 8'h45;
      S_WACK:  byte_d = 8'h4B;
      S_TOUT:  byte_d = 8'h54;
      default: byte_d = 8'h00;
    endcase
  end

  assign o_data = width'(byte_d);
  assign o_stb  = state_q inside {S_HDR, S_HI, S_LO, S_TRL, S_WACK, S_TOUT};
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        timer_q  <= '0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // a push is never taken while full, so push+pop leaves occupancy unchanged
      if (push && !pop) begin
        empty_q <= 1'b0;
        full_q  <= ((wr_ptr_q + 1'b1) == rd_ptr_q);
      end else if (pop && !push) begin
        full_q  <= 1'b0;
        empty_q <= ((rd_ptr_q + 1'b1) == wr_ptr_q);
      end

      case (state_q)
        S_IDLE: if (start_stb) begin
          len_q    <= start_len;
          cnt_q    <= '0;
          timer_q  <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          full_q   <= 1'b0;
          empty_q  <= 1'b1;
          state_q  <= start_rd ? S_HDR : S_WCNT;
        end
        S_HDR: if (o_ack) begin
          timer_q <= '0;
          state_q <= (len_q == 16'd0) ? S_TRL : S_WAIT;
        end
        S_WAIT: begin
          if (!empty_q) begin
            timer_q <= '0;
            state_q <= S_HI;
          end else if (!push) begin
            if (timer_tc) begin
              timer_q <= '0;
              state_q <= S_TOUT;
            end else begin
              timer_q <= timer_inc;
            end
          end
        end
        S_HI: if (o_ack) begin
          timer_q <= '0;
          state_q <= S_LO;
        end
        S_LO: if (o_ack) begin
          cnt_q   <= cnt_inc;
          timer_q <= '0;
          state_q <= (cnt_inc == len_q) ? S_TRL : S_WAIT;
        end
        S_WCNT: begin
          if (len_q == 16'd0) begin
            timer_q <= '0;
            state_q <= S_WACK;
          end else if (wt_done) begin
            cnt_q   <= cnt_inc;
            timer_q <= '0;
            if (cnt_inc == len_q) state_q <= S_WACK;
          end else if (timer_tc) begin
            timer_q <= '0;
            state_q <= S_TOUT;
          end else begin
            timer_q <= timer_inc;
          end
        end
        S_TRL, S_WACK, S_TOUT: if (o_ack) begin
          timer_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_to_uart.md
# sdram_to_uart

Response path from the SDRAM controller back to the UART transmitter. Once a read command is accepted it frames the returned 16-bit words into bytes: a header, then each word high byte first, then a trailer. Once a write command is accepted it counts write completions and emits a single acknowledge byte. It sits between the SDRAM controller's read-data and write-done outputs and the UART TX byte interface, alongside the UART-to-SDRAM command parser.

## Interface
- `width`, 8, UART byte width; only 8 is supported.
- `FIFO_AW`, 2, log2 of the word FIFO depth (default 4 words of 16 bits).
- `TIMEOUT`, 16'hEEEE, idle-cycle limit while waiting for data or write completions.

- `CLK`  in  1  clock.
- `RST`  in  1  reset, asynchronous, active-high.
- `start_stb`  in  1  command accepted by the parser; qualifies `start_len` and `start_rd`.
- `start_len`  in  16  number of words in the command.
- `start_rd`  in  1  1 = read response, 0 = write response.
- `start_ack`  out  1  `start_stb` consumed.
- `rd_data`  in  16  word returned by the SDRAM controller.
- `rd_stb`  in  1  `rd_data` valid.
- `rd_ack`  out  1  word accepted into the FIFO.
- `wt_done`  in  1  one-cycle pulse per completed SDRAM write.
- `o_data`  out  width  byte to UART TX.
- `o_stb`  out  1  `o_data` valid.
- `o_ack`  in  1  UART TX took the byte.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, HDR, WAIT, HI, LO, TRL, WCNT, WACK, TOUT.
- Registers:
  - 16-bit `len` and `cnt`, latched on start.
  - 16-bit timeout timer.
  - Word FIFO with `FIFO_AW`-bit pointers and a separate full/empty flag.
- **IDLE:**
  - `start_ack = start_stb`.
  - On `start_stb`: latch `len`, set `cnt` to 0, flush the FIFO.
  - Go to HDR if `start_rd` is 1, else to WCNT.
- **HDR:** drive 0x44 ("D"). On `o_ack`, go to TRL if `len` = 0, else to WAIT.
- **WAIT:**
  - If the FIFO is non-empty, go to HI.
  - Otherwise the timer increments; when it reaches `TIMEOUT`, go to TOUT.
- **HI:** drive head word [15:8]. On `o_ack`, go to LO.
- **LO:**
  - Drive head word [7:0].
  - On `o_ack`: pop the FIFO and increment `cnt`.
  - Then go to TRL if `cnt+1` = `len`, else to WAIT.
- **TRL:** drive 0x45 ("E"). On `o_ack`, go to IDLE.
- **WCNT:**
  - If `len` = 0, go to WACK immediately.
  - Each `wt_done` increments `cnt` and clears the timer; go to WACK when `cnt+1` = `len`.
  - With no `wt_done`, the timer increments; at `TIMEOUT`, go to TOUT.
- **WACK:** drive 0x4B ("K"). On `o_ack`, go to IDLE.
- **TOUT:** drive 0x54 ("T"). On `o_ack`, go to IDLE. No trailer is sent.
- **Timer:** cleared on every state change and whenever a word is pushed. It counts only in WAIT (FIFO empty) and in WCNT.
- **FIFO push:**
  - `rd_ack = rd_stb & !full & (state ∈ {WAIT, HI, LO})`.
  - A push and a pop may occur in the same cycle, except when full: a pop does not free a slot for a push in that same cycle.
  - Words presented outside these states are not acked; the controller holds them.
- **Counter width:** `cnt` never wraps. `len` = 65535 is legal and ends at `cnt` = 65534 → TRL.
- `wt_done` in any state other than WCNT is ignored.

## Timing
- **Reset values:**
  - state IDLE, FIFO empty, `cnt`/`len`/timer 0.
  - `o_stb` 0, `o_data` 0, `busy` 0.
  - `start_ack` and `rd_ack` are forced to 0 while `RST` is high.
- **Reset mid-operation:** abort immediately. No trailer; FIFO contents are discarded.
- **Output decode:**
  - `o_stb`/`o_data` are decoded from the registered state and the FIFO head only; there is no combinational path from `o_ack`.
  - `o_stb` is high in HDR, HI, LO, TRL, WACK and TOUT.
  - `o_data` is 0 in all other states.
- **Byte handshake:**
  - A byte transfers on a rising edge where `o_stb & o_ack`.
  - Until then `o_stb` and `o_data` are held stable.
- **Start latency:** `start_stb` sampled at edge N → `o_stb` with 0x44 from N+1.
- **Throughput:** with `o_ack` tied high, each word costs 3 cycles (WAIT, HI, LO). A 1-word read is HDR, WAIT, HI, LO, TRL = 5 byte-cycles.
- **Timeout:** TOUT is entered `TIMEOUT` cycles after the last progress event.

## Test plan
- **1-word read:** `start_rd=1`, `len=1`, push 0xA55A, `o_ack` tied 1 → bytes 0x44, 0xA5, 0x5A, 0x45, then IDLE, `busy=0`.
- **4-word read with backpressure:**
  - Setup: `len=4`, 6 words offered back-to-back, `o_ack` toggling every other cycle.
  - Required: the 5th word is not acked until a pop occurs, and is never acked while full.
  - Output: 10 bytes in order, ending with 0x45.
- **Write:** `start_rd=0`, `len=3`, three `wt_done` pulses 5 cycles apart → a single 0x4B after the third pulse. `len=0` → 0x4B with no pulses.
- **Read timeout:** `len=2`, one word supplied, `TIMEOUT` overridden to 20 → 0x44, hi, lo, then 0x54 after 20 idle cycles, no 0x45, back to IDLE.
- **Zero length and reset:**
  - `start_rd=1`, `len=0` → 0x44, 0x45.
  - Assert `RST` while in HI → `o_stb=0` at once; after release `start_ack` works and the FIFO is empty.
